// File: rtl/mux_truth_sweep.sv
// rtl/mux_truth_sweep.sv - sweep all 16 ABCD vectors, capture g/h truth tables, compare to expected
// Optional macro SWEEP_SYNC_INPUTS_EN: 2-flop synchronise g_in/h_in and hold each vector 2 extra cycles.
module mux_truth_sweep #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_g,
    input  logic [15:0] exp_h,
    output logic [3:0]  abcd_out,
    input  logic        g_in,
    input  logic        h_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] g_table,
    output logic [15:0] h_table,
    output logic [5:0]  err_count,
    output logic [3:0]  first_err_idx
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    logic g_smp;
    logic h_smp;

`ifdef SWEEP_SYNC_INPUTS_EN
    localparam int HOLD = SETTLE_CYCLES + 2;

    logic [1:0] g_sync_q;
    logic [1:0] h_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_sync_q <= 2'b00;
            h_sync_q <= 2'b00;
        end else begin
            g_sync_q <= {g_sync_q[0], g_in};
            h_sync_q <= {h_sync_q[0], h_in};
        end
    end

    assign g_smp = g_sync_q[1];
    assign h_smp = h_sync_q[1];
`else
    localparam int HOLD = SETTLE_CYCLES;

    assign g_smp = g_in;
    assign h_smp = h_in;
`endif

    localparam logic [8:0] CNT_LAST = 9'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] g_tab_q, g_tab_d;
    logic [15:0] h_tab_q, h_tab_d;
    logic [15:0] exp_g_q, exp_g_d;
    logic [15:0] exp_h_q, exp_h_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [5:0]  err_q, err_d;
    logic [3:0]  first_q, first_d;

    logic [15:0] mis_g;
    logic [15:0] mis_h;
    logic [5:0]  err_calc;
    logic [3:0]  first_calc;

    // Descending scan so the lowest mismatching index is the last one written.
    always_comb begin
        mis_g      = g_tab_q ^ exp_g_q;
        mis_h      = h_tab_q ^ exp_h_q;
        err_calc   = 6'd0;
        first_calc = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            err_calc = err_calc + 6'(mis_g[i]) + 6'(mis_h[i]);
            if (mis_g[i] || mis_h[i]) begin
                first_calc = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        g_tab_d = g_tab_q;
        h_tab_d = h_tab_q;
        exp_g_d = exp_g_q;
        exp_h_d = exp_h_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = 4'd0;
                    cnt_d   = 9'd0;
                    g_tab_d = 16'd0;
                    h_tab_d = 16'd0;
                    exp_g_d = exp_g;
                    exp_h_d = exp_h;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = 6'd0;
                    first_d = 4'd0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = 9'd0;
                    g_tab_d[idx_q] = g_smp;
                    h_tab_d[idx_q] = h_smp;
                    if (idx_q == 4'd15) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_CHECK: begin
                pass_d  = (mis_g == 16'd0) && (mis_h == 16'd0);
                err_d   = err_calc;
                first_d = first_calc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 9'd0;
            g_tab_q <= 16'd0;
            h_tab_q <= 16'd0;
            exp_g_q <= 16'd0;
            exp_h_q <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 6'd0;
            first_q <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            g_tab_q <= g_tab_d;
            h_tab_q <= h_tab_d;
            exp_g_q <= exp_g_d;
            exp_h_q <= exp_h_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign abcd_out      = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign g_table       = g_tab_q;
    assign h_table       = h_tab_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_mux_truth_sweep.sv
// tb/tb_mux_truth_sweep.sv - bench for mux_truth_sweep with SETTLE_CYCLES 4 and 1 instances
module tb_mux_truth_sweep;

`ifdef SWEEP_SYNC_INPUTS_EN
    localparam int SYNC_ADD = 2;
`else
    localparam int SYNC_ADD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [15:0] exp_g, exp_h;
    logic [15:0] gt_m, ht_m;

    logic        start0, start1;
    logic [3:0]  abcd0, abcd1;
    logic        g_in0, h_in0, g_in1, h_in1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] gtab0, gtab1, htab0, htab1;
    logic [5:0]  err0, err1;
    logic [3:0]  first0, first1;

    logic [3:0]  m_abcd;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_gtab, m_htab;
    logic [5:0]  m_err;
    logic [3:0]  m_first;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Function block model: truth tables indexed by the ABCD drive.
    assign g_in0 = gt_m[abcd0];
    assign h_in0 = ht_m[abcd0];
    assign g_in1 = gt_m[abcd1];
    assign h_in1 = ht_m[abcd1];

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    assign m_abcd  = sel ? abcd1  : abcd0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_pass  = sel ? pass1  : pass0;
    assign m_gtab  = sel ? gtab1  : gtab0;
    assign m_htab  = sel ? htab1  : htab0;
    assign m_err   = sel ? err1   : err0;
    assign m_first = sel ? first1 : first0;

    mux_truth_sweep #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_g(exp_g), .exp_h(exp_h),
        .abcd_out(abcd0), .g_in(g_in0), .h_in(h_in0), .busy(busy0), .done(done0),
        .pass(pass0), .g_table(gtab0), .h_table(htab0), .err_count(err0),
        .first_err_idx(first0)
    );

    mux_truth_sweep #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_g(exp_g), .exp_h(exp_h),
        .abcd_out(abcd1), .g_in(g_in1), .h_in(h_in1), .busy(busy1), .done(done1),
        .pass(pass1), .g_table(gtab1), .h_table(htab1), .err_count(err1),
        .first_err_idx(first1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctl"}, {15'd0, m_abcd, m_busy, m_done, m_pass, m_err, m_first}, 32'd0);
        chk({tag, "_tab"}, {m_gtab, m_htab}, 32'd0);
    endtask

    // One full sweep on the selected instance. With pre = 1 the start was already
    // accepted by the previous call; with nxt = 1 a new start is issued in the done cycle.
    task automatic sweep(input string nm, input logic [15:0] gm, input logic [15:0] hm,
                         input logic [15:0] eg, input logic [15:0] eh, input bit pre,
                         input bit inj, input bit nxt, input logic [15:0] ng,
                         input logic [15:0] nh);
        int hold;
        int edges;
        int holds[16];
        int busy_bad;
        int hold_bad;
        bit seen;
        int e_err;
        int e_first;
        int d;
        hold = (sel ? 1 : 4) + SYNC_ADD;
        gt_m = gm;
        ht_m = hm;
        if (!pre) begin
            exp_g = eg;
            exp_h = eh;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        exp_g = ~eg;
        exp_h = eh ^ 16'h5A5A;
        for (int i = 0; i < 16; i++) holds[i] = 0;
        edges = 0;
        seen = 1'b0;
        busy_bad = 0;
        while (!seen && edges < 2000) begin
            if (m_done) begin
                seen = 1'b1;
            end else begin
                if (edges < 16 * hold) begin
                    holds[m_abcd]++;
                    if (!m_busy) busy_bad++;
                end
                if (inj && edges == 10) start = 1'b1;
                if (inj && edges == 11) start = 1'b0;
                @(posedge clk);
                #1 edges++;
            end
        end
        start = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 16; i++) if (holds[i] != hold) hold_bad++;

        e_err = 0;
        e_first = -1;
        for (int i = 0; i < 16; i++) begin
            d = int'(gm[i] != eg[i]) + int'(hm[i] != eh[i]);
            e_err += d;
            if (d != 0 && e_first < 0) e_first = i;
        end
        if (e_first < 0) e_first = 0;

        chk({nm, "_latency"}, edges, 16 * hold + 1);
        chk({nm, "_hold"}, hold_bad, 0);
        chk({nm, "_busy_sweep"}, busy_bad, 0);
        chk({nm, "_busy_done"}, {31'd0, m_busy}, 32'd0);
        chk({nm, "_g_table"}, {16'd0, m_gtab}, {16'd0, gm});
        chk({nm, "_h_table"}, {16'd0, m_htab}, {16'd0, hm});
        chk({nm, "_err_count"}, {26'd0, m_err}, e_err);
        chk({nm, "_first_idx"}, {28'd0, m_first}, e_first);
        chk({nm, "_pass"}, {31'd0, m_pass}, {31'd0, e_err == 0});

        if (nxt) begin
            exp_g = ng;
            exp_h = nh;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            chk({nm, "_restart_busy"}, {30'd0, m_busy, m_done}, 32'd2);
            chk({nm, "_restart_clear"}, {9'd0, m_pass, m_err, m_gtab}, 32'd0);
        end else begin
            @(posedge clk);
            #1;
            chk({nm, "_done_pulse"}, {30'd0, m_busy, m_done}, 32'd0);
            chk({nm, "_results_hold"}, {m_gtab, 10'd0, m_err}, {gm, 10'd0, 6'(e_err)});
        end
    endtask

    initial begin
        int done_seen;
        logic [15:0] rg, rh, mg, mh;
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        exp_g = 16'd0;
        exp_h = 16'd0;
        gt_m  = 16'h6996;
        ht_m  = 16'hF000;
        repeat (3) @(posedge clk);
        #1 chk_zero_outputs("reset_init");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Golden model, then a single fault at ABCD=0101 chained off the done cycle
        // with a stray start mid-sweep.
        sweep("s1_golden", 16'h6996, 16'hF000, 16'h6996, 16'hF000, 1'b0, 1'b0,
              1'b1, 16'h6996, 16'hF000);
        sweep("s2_fault", 16'h69B6, 16'hF000, 16'h6996, 16'hF000, 1'b1, 1'b1,
              1'b0, 16'h0, 16'h0);

        rst_n = 1'b0;
        #1 chk_zero_outputs("reset_idle");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        sweep("s3_stuck", 16'h0000, 16'hF000, 16'h0003, 16'hF000, 1'b0, 1'b0,
              1'b0, 16'h0, 16'h0);

        // Reset while vector 7 is being driven.
        gt_m  = 16'h6996;
        ht_m  = 16'hF000;
        exp_g = 16'h6996;
        exp_h = 16'hF000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1 chk("s5_idx7", {28'd0, m_abcd}, 32'd7);
        rst_n = 1'b0;
        #1 chk("s5_reset_now", {27'd0, m_abcd, m_busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_done) done_seen++;
        end
        chk("s5_no_done", done_seen, 0);
        @(posedge clk);
        #1;
        sweep("s5_fresh", 16'h6996, 16'hF000, 16'h6996, 16'hF000, 1'b0, 1'b0,
              1'b0, 16'h0, 16'h0);

        for (int k = 0; k < 3; k++) begin
            rg = 16'($urandom);
            rh = 16'($urandom);
            mg = (k == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            mh = (k == 0) ? 16'h0 : 16'($urandom & $urandom);
            sweep($sformatf("rand%0d", k), rg, rh, rg ^ mg, rh ^ mh, 1'b0, 1'b0,
                  1'b0, 16'h0, 16'h0);
        end

        sel = 1'b1;
        @(posedge clk);
        #1;
        sweep("s6_settle1", 16'h6996, 16'hF000, 16'h6996, 16'hF000, 1'b0, 1'b0,
              1'b0, 16'h0, 16'h0);
        rg = 16'($urandom);
        rh = 16'($urandom);
        sweep("s6_rand", rg, rh, rg ^ 16'h0410, rh ^ 16'h0400, 1'b0, 1'b0,
              1'b0, 16'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
